// File: rtl/cpu_state_dumper.sv
// Trace unit: on trigger, freezes the CPU and streams PC, register file and a
// data-memory window as tagged records, counting dumps until a halt limit.
module cpu_state_dumper #(
  parameter int          NUM_REGS      = 32,
  parameter int          NUM_MEM_WORDS = 8,
  parameter logic [31:0] MEM_BASE      = 32'h0,
  parameter int          MAX_DUMPS     = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [31:0] pc_in,
  output logic        cpu_stall,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_tag,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        halt,
  output logic        missed,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_count
);

  // Handshake: a record transfers on a rising edge where out_valid && out_ready;
  // while out_valid && !out_ready the tag/data/last outputs are held unchanged.

  typedef enum logic [1:0] {S_IDLE, S_PC, S_REG, S_MEM} state_t;

  localparam int TOTAL = 1 + NUM_REGS + NUM_MEM_WORDS;
  localparam int EW    = $clog2(TOTAL + 1);

  state_t         state_q, state_d;
  logic [EW-1:0]  elem_q, elem_d;
  logic           out_valid_q, out_valid_d;
  logic [7:0]     out_tag_q, out_tag_d;
  logic [31:0]    out_data_q, out_data_d;
  logic           out_last_q, out_last_d;
  logic [7:0]     count_q, count_d;
  logic           halt_q, halt_d;
  logic           missed_q, missed_d;

  logic           is_pc, is_reg, more, start, load, done;
  logic [EW-1:0]  reg_idx, mem_idx;
  logic [7:0]     elem_tag, count_inc;
  logic [31:0]    elem_data;
  logic           elem_last;
  state_t         elem_state;

  // elem_q is the index of the next element to load into the output slot.
  assign is_pc   = (elem_q == '0);
  assign is_reg  = !is_pc && (elem_q <= EW'(NUM_REGS));
  assign reg_idx = elem_q - EW'(1);
  assign mem_idx = elem_q - EW'(1 + NUM_REGS);
  assign more    = (elem_q < EW'(TOTAL));

  assign start = (state_q == S_IDLE) && trigger && !halt_q;
  assign load  = start || ((state_q != S_IDLE) && more && (!out_valid_q || out_ready));
  assign done  = out_valid_q && out_ready && out_last_q;

  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    reg_addr = '0;
    mem_addr = '0;
    if ((state_q != S_IDLE) && more) begin
      if (is_reg)      reg_addr = 5'(reg_idx);
      else if (!is_pc) mem_addr = MEM_BASE + (32'(mem_idx) << 2);
    end
  end

  // The PC record is taken straight from pc_in at the trigger edge, so the
  // output register itself holds the PC snapshot.
  always_comb begin
    elem_tag   = 8'h80;
    elem_data  = pc_in;
    elem_last  = 1'b0;
    elem_state = S_PC;
    if (is_reg) begin
      elem_tag   = 8'(reg_idx);
      elem_data  = reg_data;
      elem_state = S_REG;
    end else if (!is_pc) begin
      elem_tag   = 8'h40 + 8'(mem_idx);
      elem_data  = mem_data;
      elem_last  = (mem_idx == EW'(NUM_MEM_WORDS - 1));
      elem_state = S_MEM;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    count_d     = count_q;
    halt_d      = halt_q;
    missed_d    = missed_q | (trigger && !start);
    if (done) begin
      state_d     = S_IDLE;
      elem_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      count_d     = count_inc;
      if ((MAX_DUMPS != 0) && ({24'd0, count_inc} == 32'(MAX_DUMPS))) halt_d = 1'b1;
    end else if (load) begin
      state_d     = elem_state;
      elem_d      = elem_q + EW'(1);
      out_valid_d = 1'b1;
      out_tag_d   = elem_tag;
      out_data_d  = elem_data;
      out_last_d  = elem_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      count_q     <= '0;
      halt_q      <= 1'b0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      count_q     <= count_d;
      halt_q      <= halt_d;
      missed_q    <= missed_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign cpu_stall = busy || start;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign halt      = halt_q;
  assign missed    = missed_q;
  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: register file / memory / CPU-write model, a
// record scoreboard built from the snapshot at trigger time, and flag model.
module tb_cpu_state_dumper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] pc_in = '0;
  logic        out_ready = 1'b1;
  logic        cpu_stall, out_valid, out_last, busy, halt, missed;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, mem_addr, mem_data, out_data;
  logic [7:0]  out_tag, dbg_count;
  logic [1:0]  dbg_state;

  logic [31:0] regs [32];
  logic [31:0] mem  [16];

  assign reg_data = regs[reg_addr];
  assign mem_data = mem[mem_addr[5:2]];

  cpu_state_dumper dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .pc_in(pc_in),
    .cpu_stall(cpu_stall), .reg_addr(reg_addr), .reg_data(reg_data),
    .mem_addr(mem_addr), .mem_data(mem_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
    .out_last(out_last), .busy(busy), .halt(halt), .missed(missed),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [40:0] exp_q [$];
  bit          m_busy, m_halt, m_missed;
  int          m_count;
  int          rec_n;
  bit          prev_stalled, stall_prev, wr_pend;
  logic [40:0] prev_rec;
  int          wr_idx;
  logic [31:0] wr_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected records of one dump, straight from the snapshot values.
  task automatic push_snapshot();
    exp_q.push_back({8'h80, pc_in, 1'b0});
    for (int i = 0; i < 32; i++) exp_q.push_back({8'(i), regs[i], 1'b0});
    for (int k = 0; k < 8; k++) exp_q.push_back({8'h40 + 8'(k), mem[k], k == 7});
  endtask

  task automatic randomize_cpu();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int k = 0; k < 16; k++) mem[k] = $urandom;
    pc_in = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
  endtask

  // One clock: sample at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [40:0] cur, e;
    bit done_now;
    @(negedge clk);
    done_now = 0;
    cur = {out_tag, out_data, out_last};
    check("busy", busy, m_busy);
    check("halt", halt, m_halt);
    check("missed", missed, m_missed);
    check("dump_count", dbg_count, m_count);
    check("cpu_stall", cpu_stall, m_busy || (trigger && !m_halt));
    if (!m_busy) check("idle_valid", out_valid, 0);
    if (prev_stalled) check("hold_stable", {out_valid, cur}, {1'b1, prev_rec});
    if (out_valid && out_ready) begin
      rec_n++;
      if (exp_q.size() == 0) check("extra_record", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("record", cur, e);
        if (e[0]) done_now = 1;
      end
    end
    if (trigger) begin
      if (!m_busy && !m_halt) begin
        push_snapshot();
        m_busy = 1;
      end else m_missed = 1;
    end
    if (done_now) begin
      m_busy = 0;
      if (m_count < 255) m_count++;
      if (m_count == 6) m_halt = 1;
    end
    prev_stalled = out_valid && !out_ready;
    prev_rec = cur;
    stall_prev = cpu_stall;
    @(posedge clk);
    #1;
    if (wr_pend && !stall_prev) begin
      regs[wr_idx] = wr_val;
      wr_pend = 0;
    end
  endtask

  function automatic logic rdy(input int rmode, input int t);
    case (rmode)
      0:       return 1'b1;
      1:       return (t % 4 == 0) || (t % 4 == 3);
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Trigger a dump and run it to completion; t1/t2 give extra trigger ticks.
  task automatic do_dump(input int rmode, input int t1, input int t2);
    int t;
    rec_n = 0;
    out_ready = rdy(rmode, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    t = 1;
    while (m_busy && t < 400) begin
      out_ready = rdy(rmode, t);
      trigger = (t == t1) || (t == t2);
      tick();
      trigger = 1'b0;
      if (rmode == 0 && t <= 41) check("back_to_back", rec_n, t);
      t++;
    end
    check("dump_bounded", t < 400, 1);
    check("record_total", rec_n, 41);
    if (rmode == 0) check("done_cycle", t, 42);
    out_ready = 1'b1;
  endtask

  initial begin
    randomize_cpu();
    wr_pend = 0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_halt", halt, 0);
    check("rst_missed", missed, 0);
    check("rst_state", dbg_state, 0);
    check("rst_count", dbg_count, 0);
    check("rst_addr", {reg_addr, mem_addr}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Directed first dump with known values.
    regs[8] = 32'd5;
    mem[1]  = 32'h1234;
    pc_in   = 32'h10;
    do_dump(0, -1, -1);

    // Backpressure plus a CPU write held off by cpu_stall.
    randomize_cpu();
    wr_pend = 1;
    wr_idx  = 9;
    wr_val  = 32'd99;
    do_dump(1, -1, -1);
    tick();
    check("cpu_write_after_stall", regs[9], 99);

    // Triggers mid-dump and in the completion cycle are ignored.
    randomize_cpu();
    do_dump(0, 10, 41);

    // Asynchronous reset at record 20.
    randomize_cpu();
    rec_n = 0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 60 && rec_n < 20; i++) tick();
    check("abort_point", rec_n, 20);
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_busy", busy, 0);
    check("async_stall", cpu_stall, 0);
    check("async_missed", missed, 0);
    check("async_count", dbg_count, 0);
    exp_q.delete();
    m_busy = 0; m_halt = 0; m_missed = 0; m_count = 0; prev_stalled = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Six dumps to the halt limit, then an ignored seventh trigger.
    randomize_cpu();
    do_dump(0, -1, -1);
    for (int d = 0; d < 5; d++) begin
      randomize_cpu();
      do_dump(2, -1, -1);
    end
    tick();
    check("halt_after_limit", halt, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("halted_no_valid", out_valid, 0);
    check("halted_missed", missed, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
Hardware trace unit downstream of the single-cycle CPU. On each trigger it freezes the CPU and reads a consistent snapshot: PC, all register-file entries and a window of data-memory words. It emits the snapshot as a tagged valid/ready record stream, for a UART/log sink or bench scoreboard. It counts completed dumps and asserts halt after a programmable number, which replaces the bench-side cycle-count stop.

Parameters:
NUM_REGS, 32, register-file entries dumped (1..32)
NUM_MEM_WORDS, 8, 32-bit data-memory words dumped (1..64)
MEM_BASE, 0, byte address of first dumped memory word (word-aligned)
MAX_DUMPS, 6, completed dumps before halt asserts; 0 = never halt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
trigger  input  1  single-cycle request to start a dump
pc_in  input  32  CPU program counter value
cpu_stall  output  1  freezes the CPU state update while a dump is in progress
reg_addr  output  5  register-file read address
reg_data  input  32  register-file read data, combinational from reg_addr
mem_addr  output  32  data-memory byte read address
mem_data  input  32  data-memory word read data, little-endian assembled, combinational
out_valid  output  1  record valid
out_ready  input  1  sink accepts record
out_tag  output  8  record tag: 0x80 = PC, 0x00+i = register i, 0x40+k = memory word k
out_data  output  32  record payload
out_last  output  1  final record of a dump
busy  output  1  dump in progress
halt  output  1  dump limit reached, sticky
missed  output  1  sticky flag: trigger arrived while busy or halted

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state to 0:
  - state=IDLE, out_valid=0, cpu_stall=0, busy=0, halt=0, missed=0, dump count=0.
  - Reset mid-dump abandons the dump with no partial completion.
- FSM states: IDLE -> PC -> REG -> MEM -> IDLE.
- IDLE:
  - trigger=1 and halt=0: latch pc_in into pc_snap; go to PC; busy=1 and cpu_stall=1 from the next cycle.
  - cpu_stall is asserted combinationally in the trigger cycle as well, so the CPU does not advance past the snapshot edge.
- Output register load rule: the output slot loads when (!out_valid || out_ready) and elements remain.
  - On load: out_valid=1, and out_tag/out_data/out_last take the current element.
  - The element index advances on each load.
  - Result: back-to-back records, 1 per cycle, with ready held high.
- Element payloads:
  - PC: one record, data = pc_snap.
  - REG: index i=0..NUM_REGS-1; reg_addr=i driven combinationally; data = reg_data sampled at load.
  - MEM: index k=0..NUM_MEM_WORDS-1; mem_addr = MEM_BASE + 4k; data = mem_data sampled at load.
- reg_addr and mem_addr are 0 outside their respective states.
- While out_valid=1 and out_ready=0, out_tag/out_data/out_last hold stable.
- out_last=1 only on memory word NUM_MEM_WORDS-1.
- Completion: the handshake on the out_last record ends the dump.
  - Next cycle: out_valid=0, busy=0, cpu_stall=0, state=IDLE.
  - The dump count increments at the same time.
  - If MAX_DUMPS != 0 and the count reaches MAX_DUMPS, halt=1 sticky.
- Records per dump: 1 + NUM_REGS + NUM_MEM_WORDS (41 with defaults).
- Minimum latency: trigger to first out_valid is 1 cycle; trigger to busy deassert is 42 cycles with ready tied high.
- Triggers ignored:
  - trigger while busy, or while halt=1: ignored, missed=1 sticky.
  - trigger in the completion cycle (last handshake): ignored, missed=1. A new dump starts only from IDLE.
- Dump count width: 8 bits, saturating at 255 (relevant only when MAX_DUMPS=0).
- cpu_stall stays high across backpressure, so the snapshot is coherent regardless of sink stalls.

Test Plan:
- Reset then single trigger, pc_in=0x10, reg[8]=5, mem word 1=0x1234, ready=1 -> 41 records on consecutive cycles:
  - first record tag 0x80 data 0x10
  - tag 0x08 data 5
  - tag 0x41 data 0x1234
  - out_last only on tag 0x47
  - busy low on cycle 42
- Backpressure: out_ready toggled 1,0,0,1 during REG -> no record dropped or duplicated; tag/data stable while ready=0; cpu_stall high throughout.
- Snapshot coherence: CPU attempts a write of 99 to reg[9] during the dump -> dumped reg[9] equals the pre-trigger value; write lands only after cpu_stall drops.
- Trigger asserted mid-dump and in the completion cycle -> ignored; missed=1; total records remain 41.
- Limit: 6 triggers, each issued after the previous dump completes -> halt=1 after the 6th out_last handshake; a 7th trigger produces no out_valid and sets missed=1.
- Async reset asserted at record 20 -> out_valid, busy and cpu_stall drop immediately; a subsequent trigger restarts at tag 0x80 with dump count 0.
